// File: rtl/dma_preload_ctrl_mc.sv
// ---------------------------------------------------------------------------
// dma_preload_ctrl_mc
//
// Multi-channel preload DMA engine. Up to NUM_CH channels raise level
// requests to copy a block of beats from external memory into on-chip
// buffers. A round-robin arbiter picks one channel at a time. Its reads go
// out on a shared request/grant read port, with up to MAX_OUTST reads in
// flight. In-order read data is written back through one buffer write port
// that carries the channel tag. Each channel keeps a "loaded" flag. A request
// for a channel that is already loaded completes at once, with no memory
// traffic, unless ch_reload is set for that channel.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   ch_req            per-channel level request (hold until ch_done)
//   ch_reload         per-channel force-reload, sampled with ch_req
//   ch_base           packed external start addresses (ADDR_W per channel)
//   ch_buf_base       packed buffer start addresses (BUF_ADDR_W per channel)
//   ch_count          packed beat counts (CNT_W per channel, 0 means 1)
//   ch_done           per-channel completion, held until ch_req falls
//   busy              engine not idle
//   mem_rd_*          external read port (req/gnt issue, in-order valid/data)
//   dma_wr_*          buffer write port (strobe, channel tag, address, data)
//   err_unexp         sticky: read data arrived with nothing outstanding
// ---------------------------------------------------------------------------
module dma_preload_ctrl_mc #(
    parameter int NUM_CH     = 3,
    parameter int ADDR_W     = 20,
    parameter int BUF_ADDR_W = 16,
    parameter int DATA_W     = 128,
    parameter int CNT_W      = 17,
    parameter int MAX_OUTST  = 4,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0]            ch_req,
    input  logic [NUM_CH-1:0]            ch_reload,
    input  logic [NUM_CH*ADDR_W-1:0]     ch_base,
    input  logic [NUM_CH*BUF_ADDR_W-1:0] ch_buf_base,
    input  logic [NUM_CH*CNT_W-1:0]      ch_count,
    output logic [NUM_CH-1:0]            ch_done,
    output logic                         busy,
    output logic                         mem_rd_req,
    output logic [ADDR_W-1:0]            mem_rd_addr,
    input  logic                         mem_rd_gnt,
    input  logic                         mem_rd_valid,
    input  logic [DATA_W-1:0]            mem_rd_data,
    output logic                         dma_wr_en,
    output logic [CH_W-1:0]              dma_wr_ch,
    output logic [BUF_ADDR_W-1:0]        dma_wr_addr,
    output logic [DATA_W-1:0]            dma_wr_data,
    output logic                         err_unexp
);

    localparam int OUT_W = 4;

    typedef enum logic [1:0] {S_IDLE, S_ARB, S_XFER, S_FIN} state_t;

    state_t                 state_q, state_d;
    logic [CH_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0]        pick_q, pick_d;
    logic [ADDR_W-1:0]      base_q, base_d;
    logic [BUF_ADDR_W-1:0]  buf_base_q, buf_base_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       issued_q, issued_d;
    logic [CNT_W-1:0]       recvd_q, recvd_d;
    logic [OUT_W-1:0]       outst_q, outst_d;
    logic [NUM_CH-1:0]      loaded_q, loaded_d;
    logic [NUM_CH-1:0]      ch_done_q, ch_done_d;
    logic                   wr_en_q, wr_en_d;
    logic [CH_W-1:0]        wr_ch_q, wr_ch_d;
    logic [BUF_ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]      wr_data_q, wr_data_d;
    logic                   err_q, err_d;

    // Per-channel views of the packed configuration buses
    logic [ADDR_W-1:0]      base_arr     [NUM_CH];
    logic [BUF_ADDR_W-1:0]  buf_base_arr [NUM_CH];
    logic [CNT_W-1:0]       count_arr    [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign base_arr[g]     = ch_base[g*ADDR_W +: ADDR_W];
        assign buf_base_arr[g] = ch_buf_base[g*BUF_ADDR_W +: BUF_ADDR_W];
        assign count_arr[g]    = ch_count[g*CNT_W +: CNT_W];
    end

    logic [NUM_CH-1:0] serving;
    logic [NUM_CH-1:0] eligible;
    logic              arb_found;
    logic [CH_W-1:0]   arb_sel;
    logic              rd_req;
    logic              gnt_fire;
    logic              vld_ok;

    // Round-robin: first eligible channel at or above rr_ptr, wrapping
    always_comb begin
        int idx;
        idx = 0;
        serving = '0;
        if (state_q == S_XFER || state_q == S_FIN) begin
            serving[pick_q] = 1'b1;
        end
        eligible  = ch_req & ~ch_done_q & ~serving;
        arb_found = 1'b0;
        arb_sel   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!arb_found && eligible[CH_W'(idx)]) begin
                arb_found = 1'b1;
                arb_sel   = CH_W'(idx);
            end
        end
    end

    always_comb begin
        rd_req   = (state_q == S_XFER) && (issued_q < cnt_q) &&
                   (outst_q < OUT_W'(MAX_OUTST));
        gnt_fire = rd_req && mem_rd_gnt;
        // Read data is accepted only against an outstanding request.
        vld_ok   = mem_rd_valid && (outst_q != '0);

        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        pick_d     = pick_q;
        base_d     = base_q;
        buf_base_d = buf_base_q;
        cnt_d      = cnt_q;
        loaded_d   = loaded_q;
        ch_done_d  = ch_done_q & ch_req;
        err_d      = err_q | (mem_rd_valid && (outst_q == '0));
        outst_d    = outst_q + OUT_W'(gnt_fire) - OUT_W'(vld_ok);
        issued_d   = issued_q + CNT_W'(gnt_fire);
        recvd_d    = recvd_q;
        wr_en_d    = 1'b0;
        wr_ch_d    = wr_ch_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        if (vld_ok) begin
            wr_en_d   = 1'b1;
            wr_ch_d   = pick_q;
            wr_addr_d = buf_base_q + BUF_ADDR_W'(recvd_q);
            wr_data_d = mem_rd_data;
            recvd_d   = recvd_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (|eligible) begin
                    state_d = S_ARB;
                end
            end
            S_ARB: begin
                if (arb_found) begin
                    pick_d     = arb_sel;
                    rr_ptr_d   = (arb_sel == CH_W'(NUM_CH - 1)) ? '0 : arb_sel + 1'b1;
                    base_d     = base_arr[arb_sel];
                    buf_base_d = buf_base_arr[arb_sel];
                    cnt_d      = (count_arr[arb_sel] == '0) ? CNT_W'(1) : count_arr[arb_sel];
                    issued_d   = '0;
                    recvd_d    = '0;
                    if (loaded_q[arb_sel] && !ch_reload[arb_sel]) begin
                        ch_done_d[arb_sel] = 1'b1;
                        state_d            = S_IDLE;
                    end else begin
                        state_d = S_XFER;
                    end
                end else begin
                    // Request withdrawn between IDLE and ARB.
                    state_d = S_IDLE;
                end
            end
            S_XFER: begin
                // Leaving on the cycle the last beat arrives puts ch_done
                // one cycle after the final buffer write.
                if (recvd_d == cnt_q) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                loaded_d[pick_q]  = 1'b1;
                ch_done_d[pick_q] = 1'b1;
                state_d           = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            pick_q     <= '0;
            base_q     <= '0;
            buf_base_q <= '0;
            cnt_q      <= '0;
            issued_q   <= '0;
            recvd_q    <= '0;
            outst_q    <= '0;
            loaded_q   <= '0;
            ch_done_q  <= '0;
            wr_en_q    <= 1'b0;
            wr_ch_q    <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            pick_q     <= pick_d;
            base_q     <= base_d;
            buf_base_q <= buf_base_d;
            cnt_q      <= cnt_d;
            issued_q   <= issued_d;
            recvd_q    <= recvd_d;
            outst_q    <= outst_d;
            loaded_q   <= loaded_d;
            ch_done_q  <= ch_done_d;
            wr_en_q    <= wr_en_d;
            wr_ch_q    <= wr_ch_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            err_q      <= err_d;
        end
    end

    // The address is built only from registered state, so it cannot move
    // while a request waits for its grant.
    assign mem_rd_req  = rd_req;
    assign mem_rd_addr = base_q + ADDR_W'(issued_q);
    assign busy        = (state_q != S_IDLE);
    assign ch_done     = ch_done_q;
    assign dma_wr_en   = wr_en_q;
    assign dma_wr_ch   = wr_ch_q;
    assign dma_wr_addr = wr_addr_q;
    assign dma_wr_data = wr_data_q;
    assign err_unexp   = err_q;

endmodule

// File: tb/tb_dma_preload_ctrl_mc.sv
module tb_dma_preload_ctrl_mc;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [2:0]   ch_req = '0;
    logic [2:0]   ch_reload = '0;
    logic [59:0]  ch_base = '0;
    logic [47:0]  ch_buf_base = '0;
    logic [50:0]  ch_count = '0;
    logic [2:0]   ch_done;
    logic         busy;
    logic         mem_rd_req;
    logic [19:0]  mem_rd_addr;
    logic         mem_rd_gnt = 1'b1;
    logic         mem_rd_valid = 1'b0;
    logic [127:0] mem_rd_data = '0;
    logic         dma_wr_en;
    logic [1:0]   dma_wr_ch;
    logic [15:0]  dma_wr_addr;
    logic [127:0] dma_wr_data;
    logic         err_unexp;

    dma_preload_ctrl_mc dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ch_req      (ch_req),
        .ch_reload   (ch_reload),
        .ch_base     (ch_base),
        .ch_buf_base (ch_buf_base),
        .ch_count    (ch_count),
        .ch_done     (ch_done),
        .busy        (busy),
        .mem_rd_req  (mem_rd_req),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_gnt  (mem_rd_gnt),
        .mem_rd_valid(mem_rd_valid),
        .mem_rd_data (mem_rd_data),
        .dma_wr_en   (dma_wr_en),
        .dma_wr_ch   (dma_wr_ch),
        .dma_wr_addr (dma_wr_addr),
        .dma_wr_data (dma_wr_data),
        .err_unexp   (err_unexp)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // Controls written only by the stimulus process
    int mem_lat = 2;
    int gnt_low_until = 0;
    int inject_at = -1;

    // Memory model and monitor state, written only by the negedge process
    int           due_q [$];
    logic [19:0]  pend_q [$];
    logic [19:0]  rq_addr_log [$];
    int           rq_cyc_log [$];
    logic [1:0]   wr_ch_log [$];
    logic [15:0]  wr_addr_log [$];
    logic [127:0] wr_data_log [$];
    int           wr_cyc_log [$];
    int           inflight = 0;
    int           max_inflight = 0;
    int           stall_n = 0;
    logic         prev_stall = 1'b0;
    logic [19:0]  prev_addr = '0;
    logic         addr_moved = 1'b0;
    logic         req_dropped = 1'b0;
    logic         req_over = 1'b0;

    function automatic logic [127:0] mk_data(input logic [19:0] a);
        return {a, 12'h5A3, ~a, 4'h0, 72'h0123456789ABCDEF01};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            due_q.delete();
            pend_q.delete();
            inflight     = 0;
            mem_rd_valid = 1'b0;
            prev_stall   = 1'b0;
        end else begin
            mem_rd_valid = 1'b0;
            mem_rd_data  = '0;
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                mem_rd_valid = 1'b1;
                mem_rd_data  = mk_data(pend_q[0]);
                void'(due_q.pop_front());
                void'(pend_q.pop_front());
            end else if (cyc == inject_at) begin
                mem_rd_valid = 1'b1;
                mem_rd_data  = 128'hBAD0_BAD0;
            end
            mem_rd_gnt = (cyc < gnt_low_until) ? 1'b0 : 1'b1;

            if (prev_stall && mem_rd_addr != prev_addr) addr_moved = 1'b1;
            if (prev_stall && !mem_rd_req) req_dropped = 1'b1;
            prev_stall = mem_rd_req && !mem_rd_gnt;
            prev_addr  = mem_rd_addr;
            if (mem_rd_req && !mem_rd_gnt) stall_n++;
            if (mem_rd_req && inflight >= 4) req_over = 1'b1;
            if (mem_rd_req && mem_rd_gnt) begin
                due_q.push_back(cyc + mem_lat);
                pend_q.push_back(mem_rd_addr);
                rq_addr_log.push_back(mem_rd_addr);
                rq_cyc_log.push_back(cyc);
                inflight++;
            end
            if (mem_rd_valid && inflight > 0 && !(mem_rd_req && mem_rd_gnt && inflight == 1 && 1'b0)) begin
                inflight--;
            end
            if (inflight > max_inflight) max_inflight = inflight;
            if (dma_wr_en) begin
                wr_ch_log.push_back(dma_wr_ch);
                wr_addr_log.push_back(dma_wr_addr);
                wr_data_log.push_back(dma_wr_data);
                wr_cyc_log.push_back(cyc);
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int c, input logic [19:0] base, input logic [15:0] bb,
                          input logic [16:0] cnt, input logic rl);
        logic [59:0] ma;
        logic [47:0] mb;
        logic [50:0] mc;
        ma = 60'hFFFFF;
        mb = 48'hFFFF;
        mc = 51'h1FFFF;
        ch_base     = (ch_base & ~(ma << (c * 20))) | (60'(base) << (c * 20));
        ch_buf_base = (ch_buf_base & ~(mb << (c * 16))) | (48'(bb) << (c * 16));
        ch_count    = (ch_count & ~(mc << (c * 17))) | (51'(cnt) << (c * 17));
        if (rl) ch_reload = ch_reload | (3'b001 << c);
        else    ch_reload = ch_reload & ~(3'b001 << c);
    endtask

    task automatic wait_done(input logic [2:0] mask, input int budget, output int dcyc);
        dcyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if ((ch_done & mask) == mask) begin
                dcyc = cyc;
                break;
            end
        end
        chk("wait_done_in_budget", (dcyc >= 0), 1'b1);
    endtask

    task automatic drop_all();
        ch_req = '0;
        @(posedge clk); #1;
        chk("done_cleared", ch_done, 3'b000);
    endtask

    initial begin
        int c0, dc, r0, w0;
        logic [1:0] ech;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs_in_reset", {ch_done, busy, mem_rd_req, dma_wr_en, err_unexp, mem_rd_addr, dma_wr_addr}, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_outputs_after_release", {ch_done, busy, mem_rd_req, dma_wr_en, err_unexp, dma_wr_data}, '0);

        // Test 1: ch0, 4 beats, L=2
        mem_lat = 2;
        r0 = rq_addr_log.size(); w0 = wr_addr_log.size();
        set_ch(0, 20'h00100, 16'h0000, 17'd4, 1'b0);
        c0 = cyc; ch_req = 3'b001;
        @(posedge clk); #1;
        chk("t1_busy_in_arb", busy, 1'b1);
        wait_done(3'b001, 100, dc);
        chk("t1_rq_count", rq_addr_log.size() - r0, 4);
        for (int i = 0; i < 4; i++) chk("t1_rq_addr", rq_addr_log[r0+i], 20'h00100 + i);
        chk("t1_first_rq_cyc", rq_cyc_log[r0], c0 + 2);
        chk("t1_wr_count", wr_addr_log.size() - w0, 4);
        for (int i = 0; i < 4; i++) begin
            chk("t1_wr_addr", wr_addr_log[w0+i], i);
            chk("t1_wr_ch", wr_ch_log[w0+i], 2'd0);
            chk("t1_wr_data", wr_data_log[w0+i], mk_data(20'h00100 + i));
        end
        chk("t1_first_wr_cyc", wr_cyc_log[w0], c0 + 5);
        chk("t1_done_cyc", dc, c0 + 9);
        chk("t1_idle_at_done", busy, 1'b0);
        drop_all();

        // Test 2: cached skip, then forced reload
        r0 = rq_addr_log.size(); w0 = wr_addr_log.size();
        set_ch(0, 20'h00100, 16'h0000, 17'd4, 1'b0);
        c0 = cyc; ch_req = 3'b001;
        wait_done(3'b001, 20, dc);
        chk("t2_skip_done_cyc", dc, c0 + 2);
        chk("t2_skip_no_rq", rq_addr_log.size() - r0, 0);
        drop_all();
        r0 = rq_addr_log.size(); w0 = wr_addr_log.size();
        set_ch(0, 20'h00100, 16'h0000, 17'd4, 1'b1);
        c0 = cyc; ch_req = 3'b001;
        wait_done(3'b001, 100, dc);
        chk("t2_reload_rq_count", rq_addr_log.size() - r0, 4);
        chk("t2_reload_wr_count", wr_addr_log.size() - w0, 4);
        chk("t2_reload_done_cyc", dc, c0 + 9);
        drop_all();

        // Test 3: three channels at once, round-robin from a fresh pointer
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
        @(posedge clk); #1;
        for (int round = 0; round < 2; round++) begin
            r0 = rq_addr_log.size(); w0 = wr_addr_log.size();
            set_ch(0, 20'h01000, 16'h0100, 17'd2, round == 1);
            set_ch(1, 20'h02000, 16'h0200, 17'd2, round == 1);
            set_ch(2, 20'h03000, 16'h0300, 17'd2, round == 1);
            ch_req = 3'b111;
            wait_done(3'b111, 300, dc);
            chk("t3_wr_count", wr_addr_log.size() - w0, 6);
            for (int i = 0; i < 6; i++) begin
                ech = 2'(i / 2);
                chk("t3_wr_ch", wr_ch_log[w0+i], ech);
                chk("t3_wr_addr", wr_addr_log[w0+i], 16'h0100 * (ech + 1) + 16'(i % 2));
                chk("t3_wr_data", wr_data_log[w0+i], mk_data(20'h01000 * (ech + 1) + 20'(i % 2)));
            end
            drop_all();
        end

        // Test 4: 16 beats, long latency, in-flight limit
        mem_lat = 10;
        r0 = rq_addr_log.size(); w0 = wr_addr_log.size();
        set_ch(1, 20'h04000, 16'h0800, 17'd16, 1'b1);
        ch_req = 3'b010;
        wait_done(3'b010, 400, dc);
        chk("t4_wr_count", wr_addr_log.size() - w0, 16);
        for (int i = 0; i < 16; i++) begin
            chk("t4_wr_addr", wr_addr_log[w0+i], 16'h0800 + i);
            chk("t4_wr_data", wr_data_log[w0+i], mk_data(20'h04000 + i));
        end
        chk("t4_max_inflight", max_inflight, 4);
        chk("t4_no_req_at_limit", req_over, 1'b0);
        drop_all();

        // Test 5a: external address wrap
        mem_lat = 2;
        r0 = rq_addr_log.size(); w0 = wr_addr_log.size();
        set_ch(2, 20'hFFFFE, 16'hFFFE, 17'd3, 1'b1);
        ch_req = 3'b100;
        wait_done(3'b100, 100, dc);
        chk("t5_wrap_rq_count", rq_addr_log.size() - r0, 3);
        chk("t5_wrap_rq0", rq_addr_log[r0], 20'hFFFFE);
        chk("t5_wrap_rq1", rq_addr_log[r0+1], 20'hFFFFF);
        chk("t5_wrap_rq2", rq_addr_log[r0+2], 20'h00000);
        chk("t5_wrap_wr2", wr_addr_log[w0+2], 16'h0000);
        drop_all();

        // Test 5b: count 0 moves exactly one beat
        r0 = rq_addr_log.size(); w0 = wr_addr_log.size();
        set_ch(0, 20'h00500, 16'h0020, 17'd0, 1'b1);
        ch_req = 3'b001;
        wait_done(3'b001, 100, dc);
        chk("t5_zero_rq_count", rq_addr_log.size() - r0, 1);
        chk("t5_zero_wr_count", wr_addr_log.size() - w0, 1);
        chk("t5_zero_wr_addr", wr_addr_log[w0], 16'h0020);
        chk("t5_zero_wr_data", wr_data_log[w0], mk_data(20'h00500));
        drop_all();

        // Test 5c: grant held low for 5 request cycles
        r0 = rq_addr_log.size(); w0 = stall_n;
        set_ch(1, 20'h00300, 16'h0030, 17'd2, 1'b1);
        c0 = cyc; gnt_low_until = cyc + 7; ch_req = 3'b010;
        wait_done(3'b010, 100, dc);
        chk("t5_stall_cycles", stall_n - w0, 5);
        chk("t5_addr_stable", addr_moved, 1'b0);
        chk("t5_req_held", req_dropped, 1'b0);
        chk("t5_first_gnt_cyc", rq_cyc_log[r0], c0 + 7);
        chk("t5_first_gnt_addr", rq_addr_log[r0], 20'h00300);
        drop_all();
        chk("t5_no_err_so_far", err_unexp, 1'b0);

        // Test 6: asynchronous reset mid-transfer, then a stray beat
        w0 = wr_addr_log.size();
        set_ch(0, 20'h00700, 16'h0040, 17'd8, 1'b1);
        ch_req = 3'b001;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (wr_addr_log.size() - w0 >= 2) break;
        end
        chk("t6_two_beats_before_reset", wr_addr_log.size() - w0, 2);
        rst_n = 1'b0;
        #1;
        chk("t6_outputs_zero", {ch_done, busy, mem_rd_req, dma_wr_en, err_unexp, mem_rd_addr, dma_wr_addr, dma_wr_ch}, '0);
        ch_req = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t6_err_clear_after_reset", err_unexp, 1'b0);
        w0 = wr_addr_log.size();
        inject_at = cyc + 1;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_err_sticky_set", err_unexp, 1'b1);
        chk("t6_stray_no_write", wr_addr_log.size() - w0, 0);
        // loaded flags were cleared: reload=0 must still fetch from memory
        mem_lat = 2;
        r0 = rq_addr_log.size();
        set_ch(0, 20'h00800, 16'h0050, 17'd1, 1'b0);
        c0 = cyc; ch_req = 3'b001;
        wait_done(3'b001, 100, dc);
        chk("t6_loaded_cleared_rq", rq_addr_log.size() - r0, 1);
        chk("t6_loaded_cleared_done_cyc", dc, c0 + 6);
        chk("t6_err_still_set", err_unexp, 1'b1);
        drop_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
